// File: rtl/hazard_stall_controller.sv
// ID-stage sequencing: load-use bubbles, taken-branch front-end flush and
// HI/LO occupancy tracking for the multi-cycle MULT/DIV unit.
module hazard_stall_controller #(
   parameter int unsigned MULT_LAT = 4,
   parameter int unsigned DIV_LAT  = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic        id_is_muldiv,
   input  logic        id_is_div,
   input  logic        id_reads_hilo,
   input  logic        id_ex_mem_read,
   input  logic [4:0]  id_ex_rt,
   input  logic        ex_branch_taken,
   output logic        pc_write,
   output logic        if_id_write,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        muldiv_start,
   output logic        muldiv_busy,
   output logic [15:0] stall_cycles
);

   typedef enum logic {IDLE, BUSY} state_t;

   // Counter preload is LAT-1 so busy spans exactly LAT cycles after launch.
   localparam logic [5:0] MULT_CNT = 6'(MULT_LAT - 1);
   localparam logic [5:0] DIV_CNT  = 6'(DIV_LAT - 1);

   state_t      state_q;
   logic [5:0]  cnt_q;
   logic        busy_q;
   logic [15:0] stall_cnt_q;

   logic load_use;
   logic hilo_hazard;
   logic stall;

   always_comb begin
      load_use = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                 ((id_uses_rs && (id_rs == id_ex_rt)) ||
                  (id_uses_rt && (id_rt == id_ex_rt)));
      hilo_hazard  = busy_q && (id_reads_hilo || id_is_muldiv);
      stall        = (load_use || hilo_hazard) && !ex_branch_taken;
      muldiv_start = id_is_muldiv && !stall && !ex_branch_taken;

      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      if (ex_branch_taken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (stall) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 6'd0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (muldiv_start) begin
                  state_q <= BUSY;
                  busy_q  <= 1'b1;
                  cnt_q   <= id_is_div ? DIV_CNT : MULT_CNT;
               end
            end
            BUSY: begin
               // In-flight ops keep counting even across a taken branch.
               if (cnt_q == 6'd0) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 6'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= 16'd0;
      end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign muldiv_busy  = busy_q;
   assign stall_cycles = stall_cnt_q;

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Pipeline sequencing block sitting beside the ID stage of the 5-stage MIPS core. It detects load-use hazards, which forwarding cannot cover, and inserts one bubble for each. It flushes the front end on a taken branch resolved in EX. It also owns a multi-cycle MULT/DIV occupancy tracker that launches HI/LO operations and stalls dependent or conflicting instructions until the result is ready. It drives PC/IF-ID write enables and IF-ID/ID-EX flush controls, and keeps a saturating stall-cycle counter for debug readout.

## Interface
- MULT_LAT, default 4: cycles the mul/div unit is occupied by MULT/MULTU (1..63).
- DIV_LAT, default 8: cycles occupied by DIV/DIVU (1..63).
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- id_rs  input  5  rs field of instruction in ID.
- id_rt  input  5  rt field of instruction in ID.
- id_uses_rs  input  1  ID instruction reads rs.
- id_uses_rt  input  1  ID instruction reads rt.
- id_is_muldiv  input  1  ID instruction is MULT/MULTU/DIV/DIVU.
- id_is_div  input  1  qualifies id_is_muldiv: 1 = DIV/DIVU.
- id_reads_hilo  input  1  ID instruction is MFHI/MFLO.
- id_ex_mem_read  input  1  instruction in EX is a load.
- id_ex_rt  input  5  destination of the load in EX.
- ex_branch_taken  input  1  branch/jump in EX resolved taken.
- pc_write  output  1  PC update enable.
- if_id_write  output  1  IF/ID register enable.
- if_id_flush  output  1  clear IF/ID to NOP.
- id_ex_flush  output  1  load bubble into ID/EX.
- muldiv_start  output  1  one-cycle launch pulse to mul/div unit.
- muldiv_busy  output  1  registered; unit occupied.
- stall_cycles  output  16  registered saturating count of stall cycles.

## Operation
- load_use = id_ex_mem_read & (id_ex_rt != 0) & ((id_uses_rs & id_rs == id_ex_rt) | (id_uses_rt & id_rt == id_ex_rt)).
- hilo_hazard = muldiv_busy & (id_reads_hilo | id_is_muldiv).
- stall = (load_use | hilo_hazard) & ~ex_branch_taken.
- Priority: branch flush over stall. With ex_branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1, no start.
- With stall: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_flush=1.
- Otherwise: pc_write=1, if_id_write=1, both flushes 0.
- muldiv_start = id_is_muldiv & ~stall & ~ex_branch_taken. It is combinational and marks the cycle the op leaves ID.
- FSM, 2 states:
  - IDLE: muldiv_busy=0. On muldiv_start, go to BUSY with cnt = (id_is_div ? DIV_LAT : MULT_LAT) - 1.
  - BUSY: muldiv_busy=1. If cnt==0, go to IDLE; else cnt decrements.
- Back-to-back launch cannot occur, because a muldiv in ID while BUSY is a hilo_hazard.
- The 6-bit cnt never wraps. The counter is loaded only in IDLE.
- stall_cycles increments on every cycle with stall=1 and saturates at 16'hFFFF. Flush-only cycles are not counted.

## Timing
- Hazard and flush outputs and muldiv_start are combinational from inputs and current state, valid in the same cycle.
- muldiv_busy and stall_cycles are registered.
- Launch in cycle t: muldiv_busy=1 in cycles t+1..t+LAT, then 0 at t+LAT+1.
- An MFHI arriving in ID at t+1 stalls through t+LAT and proceeds at t+LAT+1.
- A load-use stall lasts exactly 1 cycle. Next cycle the load has moved to MEM and forwarding covers it.
- While reset=1: state=IDLE, cnt=0, muldiv_busy=0, stall_cycles=0. Combinational outputs follow inputs with busy=0, so with all inputs 0: pc_write=1, if_id_write=1, flushes=0, start=0.
- Reset asserted mid-BUSY aborts immediately to IDLE with no pending completion.
- Branch taken in the same cycle as a muldiv in ID: no launch, FSM unchanged.
- Branch taken while BUSY: FSM keeps counting. In-flight ops are not cancelled.

## Test plan
- Load-use: id_ex_mem_read=1, id_ex_rt=5, id_rs=5, id_uses_rs=1 -> one cycle of pc_write=0, if_id_write=0, id_ex_flush=1; stall_cycles 0->1.
- Zero register: same as above with id_ex_rt=id_rs=0 -> no stall, pc_write=1.
- Mult then MFHI: MULT in ID at t, MFHI in ID from t+1 -> muldiv_start=1 at t; busy t+1..t+4; stall at t+1..t+4; MFHI proceeds at t+5; stall_cycles=4.
- DIV latency: DIV launch at t -> muldiv_busy high for exactly 8 cycles.
- Branch priority: load_use true and ex_branch_taken=1 -> if_id_flush=1, id_ex_flush=1, pc_write=1, stall_cycles unchanged. Muldiv in ID under the same branch -> no start.
- Async reset mid-DIV: reset pulsed 3 cycles after launch, between clock edges -> muldiv_busy=0 immediately; after release a new MULT launches and busies for 4 cycles.
